// File: rtl/calc_seq_if.sv
// -----------------------------------------------------------------------------
// calc_seq_if
// ALU bus between the calculator sequencer and the ALU instance.
//   alu_op     [3:0]  operation code        (sequencer -> ALU)
//   alu_op1    [31:0] sign-extended acc     (sequencer -> ALU)
//   alu_op2    [31:0] sign-extended operand (sequencer -> ALU)
//   alu_result [31:0] combinational result  (ALU -> sequencer)
//   alu_zero          result-is-zero flag   (ALU -> sequencer)
// Modports: master = sequencer side, slave = ALU side.
// -----------------------------------------------------------------------------
interface calc_seq_if;
  logic [3:0]  alu_op;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_result;
  logic        alu_zero;

  modport master (
    output alu_op, alu_op1, alu_op2,
    input  alu_result, alu_zero
  );

  modport slave (
    input  alu_op, alu_op1, alu_op2,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/calc_seq.sv
// -----------------------------------------------------------------------------
// calc_seq
// Program sequencer for the calculator datapath. Holds DEPTH (op, operand)
// steps, owns the DATA_W-bit accumulator and replays the program through the
// external combinational ALU on start, writing every result back to acc.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_prog_we/addr/op/data  program slot write (IDLE only)
//   i_len               number of steps to run, clamped to DEPTH, sampled on start
//   i_start, i_clear    begin run / zero accumulator (IDLE only, clear wins)
//   i_abort             terminate a run in progress
//   o_busy, o_done      run in progress / one-cycle end-of-run pulse
//   o_step              current program counter
//   o_acc               accumulator
//   o_zhalt             run ended early on a zero ALU result
//   alu                 ALU bus (calc_seq_if.master)
//
// Optional feature: define CALC_SEQ_ZERO_HALT_EN to end a run early when the
// ALU reports a zero result before the last step. Without it alu_zero is
// ignored and o_zhalt stays 0.
// -----------------------------------------------------------------------------
module calc_seq #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_prog_we,
  input  logic [AW-1:0]     i_prog_addr,
  input  logic [3:0]        i_prog_op,
  input  logic [DATA_W-1:0] i_prog_data,
  input  logic [AW:0]       i_len,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [AW-1:0]     o_step,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_zhalt,
  calc_seq_if.master        alu
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_DONE} state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic [3+DATA_W:0]   r_mem [DEPTH];
  logic [3:0]          r_op;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_acc;
  logic [AW-1:0]       r_step;
  logic [AW:0]         r_len;
  logic                r_zhalt;

  logic [AW:0]         w_len_clamp;
  logic                w_last;
  logic                w_acc_we;
  logic                w_acc_clr;
  logic                w_step_clr;
  logic                w_step_inc;
  logic                w_len_load;
  logic                w_zhalt_set;
  logic                w_zhalt_clr;
  logic                w_unused_bits;

  assign w_len_clamp = (i_len > LP_DEPTH) ? LP_DEPTH : i_len;
  assign w_last      = ({1'b0, r_step} == (r_len - LP_ONE));

  // NOTE: program memory has no reset on purpose; resetting it would turn a
  // plain RAM into a bank of reset flops and the contents are always written
  // before use.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && i_prog_we) begin
      r_mem[i_prog_addr] <= {i_prog_op, i_prog_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_acc_we     = 1'b0;
    w_acc_clr    = 1'b0;
    w_step_clr   = 1'b0;
    w_step_inc   = 1'b0;
    w_len_load   = 1'b0;
    w_zhalt_set  = 1'b0;
    w_zhalt_clr  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_clear) begin
          w_acc_clr   = 1'b1;
          w_zhalt_clr = 1'b1;
        end else if (i_start) begin
          w_len_load  = 1'b1;
          w_zhalt_clr = 1'b1;
          if (i_len == '0) begin
            w_state_next = ST_DONE;
          end else begin
            w_step_clr   = 1'b1;
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        w_state_next = i_abort ? ST_IDLE : ST_EXEC;
      end
      ST_EXEC: begin
        if (i_abort) begin
          // Aborting in EXEC drops this cycle's writeback.
          w_state_next = ST_IDLE;
        end else begin
          w_acc_we = 1'b1;
          if (w_last) begin
            w_state_next = ST_DONE;
          end
`ifdef CALC_SEQ_ZERO_HALT_EN
          else if (alu.alu_zero) begin
            w_zhalt_set  = 1'b1;
            w_state_next = ST_DONE;
          end
`endif
          else begin
            w_step_inc   = 1'b1;
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_step  <= '0;
      r_len   <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_zhalt <= 1'b0;
    end else begin
      if (w_len_load) begin
        r_len <= w_len_clamp;
      end
      if (w_step_clr) begin
        r_step <= '0;
      end else if (w_step_inc) begin
        r_step <= r_step + AW'(1);
      end
      if (r_state == ST_FETCH) begin
        {r_op, r_data} <= r_mem[r_step];
      end
      // Only the low DATA_W bits of the ALU result are kept.
      if (w_acc_clr) begin
        r_acc <= '0;
      end else if (w_acc_we) begin
        r_acc <= alu.alu_result[DATA_W-1:0];
      end
      if (w_zhalt_clr) begin
        r_zhalt <= 1'b0;
      end else if (w_zhalt_set) begin
        r_zhalt <= 1'b1;
      end
    end
  end

  // ALU inputs are zero outside EXEC so the ALU sees quiet operands.
  always_comb begin
    alu.alu_op  = '0;
    alu.alu_op1 = '0;
    alu.alu_op2 = '0;
    if (r_state == ST_EXEC) begin
      alu.alu_op  = r_op;
      alu.alu_op1 = {{(32-DATA_W){r_acc[DATA_W-1]}}, r_acc};
      alu.alu_op2 = {{(32-DATA_W){r_data[DATA_W-1]}}, r_data};
    end
  end

`ifdef CALC_SEQ_ZERO_HALT_EN
  assign w_unused_bits = ^alu.alu_result[31:DATA_W];
`else
  assign w_unused_bits = ^{alu.alu_result[31:DATA_W], alu.alu_zero};
`endif

  assign o_busy  = (r_state != ST_IDLE);
  // An abort in DONE also suppresses the done pulse.
  assign o_done  = (r_state == ST_DONE) && !i_abort;
  assign o_step  = r_step;
  assign o_acc   = r_acc;
  assign o_zhalt = r_zhalt;

endmodule
